// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pins, memory fetch port and busy flag shared between
// the flash responder (slave) and the controller/memory side (master).
interface spi_flash_responder_if;
   logic        spiScl;
   logic        spiNCs;
   logic        spiSi;
   logic        spiSo;
   logic        spiSoDriven;
   logic [23:0] memAddress;
   logic        memReadRequest;
   logic [7:0]  memReadData;
   logic        memReadValid;
   logic        busyIn;
   modport slave (
      input  spiScl, spiNCs, spiSi, memReadData, memReadValid, busyIn,
      output spiSo, spiSoDriven, memAddress, memReadRequest
   );
   modport master (
      output spiScl, spiNCs, spiSi, memReadData, memReadValid, busyIn,
      input  spiSo, spiSoDriven, memAddress, memReadRequest
   );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled SPI mode-0 serial-NOR responder (JEDEC ID,
// status, WEL set/clear, sequential read with one-byte prefetch).
module spi_flash_responder #(
   parameter logic [7:0] manufacturingId = 8'hEF,
   parameter logic [7:0] memoryType      = 8'h40,
   parameter logic [7:0] memoryCap       = 8'h18
) (
   input logic                   clock,
   input logic                   reset,
   spi_flash_responder_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, ID_OUT, STAT_OUT, DATA_OUT, IGNORE} stateType;
   stateType    state;
   logic [2:0]  sclSync;
   logic [2:0]  csSync;
   logic [1:0]  siSync;
   logic [4:0]  bitCount;
   logic [23:0] shiftIn;
   logic [7:0]  outShift;
   logic [2:0]  outCount;
   logic [1:0]  idIndex;
   logic        wel;
   logic        fetchPending;
   logic        bufferValid;
   logic [7:0]  bufferData;
   logic        underrun;
   logic        sclRise;
   logic        sclFall;
   logic        csFall;
   logic        streaming;
   logic [23:0] shiftNext;
   logic [7:0]  idByte;
   logic [7:0]  nextByte;
   assign sclRise   = sclSync[1] & ~sclSync[2];
   assign sclFall   = ~sclSync[1] & sclSync[2];
   assign csFall    = ~csSync[1] & csSync[2];
   assign streaming = state inside {ID_OUT, STAT_OUT, DATA_OUT};
   assign shiftNext = {shiftIn[22:0], siSync[1]};
   assign idByte    = idIndex == 2'd0 ? manufacturingId : idIndex == 2'd1 ? memoryType : memoryCap;
   // An empty prefetch buffer at load time sends 0xFF and records an underrun.
   assign nextByte  = state == ID_OUT ? idByte :
                      state == STAT_OUT ? {6'd0, wel, bus.busyIn} :
                      bufferValid ? bufferData : 8'hFF;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sclSync            <= '0;
         csSync             <= '0;
         siSync             <= '0;
         state              <= IDLE;
         bitCount           <= '0;
         shiftIn            <= '0;
         outShift           <= '0;
         outCount           <= '0;
         idIndex            <= '0;
         wel                <= 1'b0;
         fetchPending       <= 1'b0;
         bufferValid        <= 1'b0;
         bufferData         <= '0;
         underrun           <= 1'b0;
         bus.spiSo          <= 1'b0;
         bus.spiSoDriven    <= 1'b0;
         bus.memAddress     <= '0;
         bus.memReadRequest <= 1'b0;
      end else begin
         sclSync            <= {sclSync[1:0], bus.spiScl};
         csSync             <= {csSync[1:0], bus.spiNCs};
         siSync             <= {siSync[0], bus.spiSi};
         bus.memReadRequest <= 1'b0;
         if (bus.memReadValid && fetchPending) begin
            bufferData   <= bus.memReadData;
            bufferValid  <= 1'b1;
            fetchPending <= 1'b0;
         end
         // Deselect beats any coincident SCL edge and drops outstanding fetches.
         if (csSync[1]) begin
            state           <= IDLE;
            bus.spiSoDriven <= 1'b0;
            fetchPending    <= 1'b0;
            bufferValid     <= 1'b0;
         end else if (csFall) begin
            state    <= CMD;
            bitCount <= '0;
            underrun <= 1'b0;
         end else if (sclRise) begin
            shiftIn  <= shiftNext;
            bitCount <= bitCount + 5'd1;
            if (state == CMD && bitCount == 5'd7) begin
               bitCount <= '0;
               outCount <= '0;
               idIndex  <= '0;
               case (shiftNext[7:0])
                  8'h9F: begin state <= ID_OUT; bus.spiSoDriven <= 1'b1; end
                  8'h05: begin state <= STAT_OUT; bus.spiSoDriven <= 1'b1; end
                  8'h06: begin state <= IGNORE; wel <= 1'b1; end
                  8'h04: begin state <= IGNORE; wel <= 1'b0; end
                  8'h03: state <= ADDR;
                  default: state <= IGNORE;
               endcase
            end else if (state == ADDR && bitCount == 5'd23) begin
               bus.memAddress     <= shiftNext;
               bus.memReadRequest <= 1'b1;
               fetchPending       <= 1'b1;
               bufferValid        <= 1'b0;
               state              <= DATA_OUT;
               bus.spiSoDriven    <= 1'b1;
            end
         end else if (sclFall && streaming) begin
            outCount <= outCount + 3'd1;
            if (outCount == 3'd0) begin
               bus.spiSo <= nextByte[7];
               outShift  <= {nextByte[6:0], 1'b0};
               idIndex   <= idIndex == 2'd2 ? 2'd0 : idIndex + 2'd1;
               if (state == DATA_OUT) begin
                  bus.memAddress     <= bus.memAddress + 24'd1;
                  bus.memReadRequest <= 1'b1;
                  fetchPending       <= 1'b1;
                  bufferValid        <= 1'b0;
                  underrun           <= underrun | ~bufferValid;
               end
            end else begin
               bus.spiSo <= outShift[7];
               outShift  <= {outShift[6:0], 1'b0};
            end
         end
      end
   end
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
Single-line SPI mode-0 responder that emulates the serial-NOR command subset used by the flash controller: JEDEC ID, status read, write-enable latch control, and sequential read. All SPI pins are oversampled in the system clock domain. Read data is fetched byte by byte from a simple on-chip memory port. Used as the flash-side counterpart in simulation benches and as an FPGA loop-back target for the controller's single-line path.

Parameters:
manufacturingId, 8'hEF, byte 0 returned by command 0x9F
memoryType, 8'h40, byte 1 returned by command 0x9F
memoryCap, 8'h18, byte 2 returned by command 0x9F

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active low
spiScl  in  1  SPI clock from the controller, idle low
spiNCs  in  1  chip select, active low
spiSi  in  1  serial data in (controller to responder)
spiSo  out  1  serial data out, MSB first
spiSoDriven  out  1  high while spiSo must be driven onto the pad; low means tristate
memAddress  out  24  byte address of the current memory fetch
memReadRequest  out  1  one-cycle fetch strobe
memReadData  in  8  fetched byte
memReadValid  in  1  one-cycle strobe marking memReadData valid
busyIn  in  1  reported as status bit 0

Behaviour:
- Input conditioning: spiScl, spiNCs and spiSi each pass through a 2-FF synchronizer. Edges are detected from the second stage against a third register.
- Timing constraint: SCL high and low phases are each at least 6 clock cycles.
- Reset values (reset low): spiSo 0, spiSoDriven 0, memReadRequest 0, memAddress 0, write-enable latch (WEL) 0, state IDLE, bit counters 0.
- Bit timing:
  - spiSi is sampled on each synchronized SCL rising edge.
  - spiSo changes only on synchronized SCL falling edges, except that the MSB of the first response byte is presented on the falling edge that follows the last input bit.
- Synchronized nCs high forces state IDLE and spiSoDriven 0 in the cycle after detection, regardless of state.
- Synchronized nCs falling edge resets the bit counter and enters CMD.
- States:
  - IDLE: wait for nCs falling edge.
  - CMD: shift 8 bits. On the 8th rising edge, decode:
    - 0x9F → ID_OUT.
    - 0x05 → STAT_OUT.
    - 0x06 → set WEL; go to IGNORE.
    - 0x04 → clear WEL; go to IGNORE.
    - 0x03 → ADDR.
    - Any other command → IGNORE.
  - ADDR: shift 24 bits MSB first. On the 24th rising edge, load memAddress, pulse memReadRequest for 1 cycle, then go to DATA_OUT.
  - ID_OUT: stream manufacturingId, memoryType, memoryCap. After the third byte, continue by repeating from manufacturingId.
  - STAT_OUT: stream {6'd0, WEL, busyIn}, re-sampled at each byte boundary, repeated for as long as nCs stays low.
  - DATA_OUT:
    - Each byte is loaded into the output shifter from the prefetch buffer.
    - On every load: increment memAddress modulo 2^24 (0xFFFFFF wraps to 0x000000) and pulse memReadRequest for the next byte.
    - Memory latency from request to memReadValid must be at most 4 cycles. memReadValid outside a pending request is ignored.
    - If the buffer is still empty when a load is due, send 0xFF and set an internal underrun flag. The flag is visible only to the bench, via hierarchy.
  - IGNORE: spiSoDriven 0; stay until nCs goes high.
- spiSoDriven is 1 only in ID_OUT, STAT_OUT and DATA_OUT while nCs is low.
- Simultaneous events:
  - nCs rising in the same cycle as an SCL edge: the nCs rise wins and the SCL edge is discarded.
  - A pending memReadValid arriving after nCs has gone high is dropped.
- Reset asserted mid-transaction: all state returns to reset values immediately. After reset is released, the responder waits for a fresh nCs falling edge, so a transaction already in progress on the bus is ignored.

Test Plan:
1. JEDEC ID: nCs low, send 0x9F, clock 32 more bits → SO bytes EF 40 18 EF; spiSoDriven 1 from the first output bit until nCs goes high.
2. Status and WEL: send 0x06, raise nCs; then send 0x05 with busyIn=1 and clock 8 bits → SO 0x03. Repeat after sending 0x04 → SO 0x01.
3. Read: send 0x03 000010, memory model returns addr[7:0] with 2-cycle latency, clock 24 bits → SO 10 11 12; memReadRequest pulses at addresses 0x000010, 0x000011, 0x000012, 0x000013.
4. Wrap: send 0x03 FFFFFE, clock 24 bits → fetch addresses FFFFFE, FFFFFF, 000000; data FE FF 00.
5. Unknown command and abort: send 0xAB then 8 more clocks → spiSoDriven stays 0. Raise nCs after bit 12 of a read, then issue a new 0x9F → EF returned correctly; the late memReadValid is ignored.
6. Reset mid-read: assert reset during the 2nd data byte → spiSo, spiSoDriven, memReadRequest and WEL all 0 immediately; further SCL edges with nCs still low produce no output until nCs cycles high then low.
